// File: rtl/fmap_mem_arb_if.sv
// Bundle of requester-side and memory-side signals for fmap_mem_arb.
//
// Handshake: a requester holds req[i] (with we/addr/wdata valid) for as
// long as it wants the memory port.  gnt[i] is the "ready" half: a beat
// transfers in every cycle where req[i] and gnt[i] are both 1.  Read data
// comes back on the shared rdata bus qualified by rvalid[i] one cycle after
// the read beat.
interface fmap_mem_arb_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [2:0]      req;
    logic [2:0]      we;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt;
    logic [2:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    // Arbiter side: receives requests, drives grants and the memory command.
    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requesters plus memory: drive requests and read data, observe the rest.
    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/fmap_mem_arb.sv
// fmap_mem_arb: three-way round-robin arbiter (uart, conv, pool) in front of
// a single-port memory.  A granted requester keeps the port for up to
// MAX_BURST beats or until it drops req; every release is followed by at
// least one idle cycle before the next grant.
//
// Optional feature: define FMAP_ARB_STALL_CNT_EN to add per-requester
// saturating stall counters (stall_cnt) with a synchronous clear (stat_clr).
module fmap_mem_arb #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fmap_mem_arb_if.slave        bus,
    output logic                 dbg_state
`ifdef FMAP_ARB_STALL_CNT_EN
    ,
    input  logic                 stat_clr,
    output logic [3*16-1:0]      stall_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Beat count at which the current burst is finished.
    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    state_t     state;
    logic [2:0] gnt_q;
    logic [1:0] owner;
    logic [1:0] last_owner;
    logic [7:0] beat_cnt;
    logic [2:0] rvalid_q;

    logic       beat;
    logic       owner_req;
    logic       owner_we;
    logic [1:0] pick;

    // Successor of requester i in the uart -> conv -> pool -> uart ring.
    function automatic logic [1:0] next_idx(input logic [1:0] i);
        next_idx = (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        onehot = 3'b001 << i;
    endfunction

    // Request and write-enable of the current owner.
    always_comb begin
        owner_req = 1'b0;
        owner_we  = 1'b0;
        case (owner)
            2'd0: begin
                owner_req = bus.req[0];
                owner_we  = bus.we[0];
            end
            2'd1: begin
                owner_req = bus.req[1];
                owner_we  = bus.we[1];
            end
            2'd2: begin
                owner_req = bus.req[2];
                owner_we  = bus.we[2];
            end
            default: begin
                owner_req = 1'b0;
                owner_we  = 1'b0;
            end
        endcase
    end

    // A beat is a cycle where the registered grant meets a live request;
    // nothing reaches the memory while reset is held.
    assign beat = (|(gnt_q & bus.req)) & ~rst;

    // Round-robin choice: scan starting at the requester after last_owner,
    // so the previous owner is considered last.
    always_comb begin
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = next_idx(last_owner);
        c2 = next_idx(c1);
        if (bus.req[c1]) begin
            pick = c1;
        end else if (bus.req[c2]) begin
            pick = c2;
        end else begin
            pick = last_owner;
        end
    end

    // Memory command mux, driven from the registered owner; zero when idle.
    always_comb begin
        bus.mem_en    = beat;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (beat) begin
            bus.mem_we = owner_we;
            case (owner)
                2'd0: begin
                    bus.mem_addr  = bus.addr[0 +: AW];
                    bus.mem_wdata = bus.wdata[0 +: DW];
                end
                2'd1: begin
                    bus.mem_addr  = bus.addr[AW +: AW];
                    bus.mem_wdata = bus.wdata[DW +: DW];
                end
                2'd2: begin
                    bus.mem_addr  = bus.addr[2*AW +: AW];
                    bus.mem_wdata = bus.wdata[2*DW +: DW];
                end
                default: begin
                    bus.mem_addr  = '0;
                    bus.mem_wdata = '0;
                end
            endcase
        end
    end

    // Grant FSM: IDLE picks the next owner, BUSY counts beats until the
    // owner lets go or the burst limit is hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt_q      <= 3'b000;
            owner      <= 2'd0;
            last_owner <= 2'd2;
            beat_cnt   <= 8'd0;
            rvalid_q   <= 3'b000;
        end else begin
            // Read data returns one cycle after a read beat, including the
            // final beat of a burst.
            rvalid_q <= (beat && !owner_we) ? onehot(owner) : 3'b000;

            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        gnt_q    <= onehot(pick);
                        owner    <= pick;
                        beat_cnt <= 8'd0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!owner_req) begin
                        gnt_q      <= 3'b000;
                        last_owner <= owner;
                        state      <= IDLE;
                    end else begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (beat_cnt == LAST_BEAT) begin
                            gnt_q      <= 3'b000;
                            last_owner <= owner;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    gnt_q <= 3'b000;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = bus.mem_rdata;
    assign dbg_state  = (state == BUSY);

`ifdef FMAP_ARB_STALL_CNT_EN
    logic [15:0] stall_q [3];

    // Count cycles each requester spends asking without holding the grant.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst || stat_clr) begin
                stall_q[i] <= 16'd0;
            end else if (bus.req[i] && !gnt_q[i] && stall_q[i] != 16'hFFFF) begin
                stall_q[i] <= stall_q[i] + 16'd1;
            end
        end
    end

    assign stall_cnt = {stall_q[2], stall_q[1], stall_q[0]};
`endif

endmodule

// File: doc/fmap_mem_arb.md
FMAP_MEM_ARB -- requirements
Module: fmap_mem_arb

Interface
REQ-001 Parameter AW, default 16, memory address width.
REQ-002 Parameter DW, default 16, memory data width.
REQ-003 Parameter MAX_BURST, default 16, maximum beats per grant (range 1..255).
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  3  per-requester request; bit0 uart, bit1 conv, bit2 pool.
REQ-007 we  in  3  per-requester write enable, valid with req.
REQ-008 addr  in  3*AW  per-requester address; slice i is [i*AW +: AW].
REQ-009 wdata  in  3*DW  per-requester write data, sliced like addr.
REQ-010 gnt  out  3  registered one-hot grant.
REQ-011 rvalid  out  3  per-requester read-data valid.
REQ-012 rdata  out  DW  shared read data, equal to mem_rdata.
REQ-013 mem_en, mem_we  out  1 each  single-port memory command.
REQ-014 mem_addr, mem_wdata  out  AW, DW  memory command fields.
REQ-015 mem_rdata  in  DW  memory read data, one cycle after a read command.

Function
REQ-016 FSM has two states: IDLE and BUSY.
REQ-017 In IDLE with req nonzero, select a requester round-robin, starting at the index after last_owner; set gnt one-hot for it, clear beat_cnt and enter BUSY on the next edge.
REQ-018 In IDLE with req zero, gnt stays 0 and last_owner is unchanged.
REQ-019 A beat occurs in any cycle where gnt[i] and req[i] are both 1; mem_en = 1 and mem_we, mem_addr and mem_wdata come from requester i in that same cycle (combinational from the registered gnt).
REQ-020 mem_en is 0 in every cycle with no beat; the other mem_* outputs are don't-care while mem_en is 0.
REQ-021 Each beat increments the 8-bit beat_cnt.
REQ-022 BUSY -> IDLE, clearing gnt and setting last_owner to the owner, when:
  - the owner drops req (no beat that cycle), or
  - the owner completes beat number MAX_BURST.
REQ-023 Requests from non-owners never pre-empt an ongoing burst.
REQ-024 After each release there is at least one IDLE cycle before the next grant.
REQ-025 rvalid[i] is registered: it is 1 in the cycle after a read beat (we=0) by requester i, and 0 otherwise.
REQ-026 At most one rvalid bit is 1 in any cycle.
REQ-027 A read beat on the final beat of a burst still produces rvalid after the release.
REQ-028 A requester never receives gnt in the cycle immediately after its own release, unless it is the only requester.
REQ-029 Simultaneous requests with last_owner = pool are granted in the order uart, conv, pool.

Reset
REQ-030 When rst is 1 at a clock edge:
  - state becomes IDLE; gnt, rvalid and beat_cnt become 0;
  - last_owner becomes pool, so uart has first priority.
REQ-031 Reset asserted mid-burst drops gnt at that edge and discards the pending read: no rvalid follows.
REQ-032 While rst is held, all outputs except rdata are 0.

Configuration
REQ-033 Macro FMAP_ARB_STALL_CNT_EN, when defined, adds:
  - input stat_clr (1 bit);
  - output stall_cnt (3*16 bits), one counter per requester.
REQ-034 With the macro defined, counter i increments by 1 each cycle req[i]=1 and gnt[i]=0.
REQ-035 The counters saturate at 16'hFFFF.
REQ-036 rst or stat_clr clears all counters to 0; stat_clr takes priority over increment in the same cycle.
REQ-037 Without the macro, the stat_clr and stall_cnt ports and all counter logic are absent; arbitration behaviour is identical.

Verification
REQ-038 Reset, then uart req with we=1 and addr 0x0010..0x0013 for 4 beats, then req dropped -> 4 write beats on the memory port, gnt[0] falls the cycle after req drops.
REQ-039 conv holds req with we=0 for 20 cycles, MAX_BURST=16 -> exactly 16 beats, then gnt released for 1 cycle, then re-granted to conv for the remaining beats; rvalid[1] pulses 1 cycle after each read beat.
REQ-040 All three requesters raise req in the same cycle after reset, each doing 2-beat bursts -> grant order uart, conv, pool, with one IDLE cycle between bursts.
REQ-041 rst asserted on the 3rd beat of a pool read burst -> gnt=0 and no rvalid[2] the following cycle; the next grant goes to uart.
REQ-042 With FMAP_ARB_STALL_CNT_EN defined, pool waits 5 cycles while uart owns the port -> stall_cnt pool slice = 5; stat_clr pulse -> 0.
